// File: rtl/uart_boot_loader_if.sv
// Boot-loader port bundle: byte stream in from the UART receiver, instruction
// memory write port and CPU/status flags out.
interface uart_boot_loader_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              rx_ready;
    logic [7:0]        rx_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;
    logic              busy;

    modport master (
        output rx_ready, rx_data,
        input  mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err, busy
    );

    modport slave (
        input  rx_ready, rx_data,
        output mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err, busy
    );
endinterface

// File: rtl/uart_boot_loader.sv
// Frame parser that loads 32-bit words from a UART byte stream into instruction
// memory, checks an XOR checksum and holds the CPU in reset while loading.
module uart_boot_loader #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned TIMEOUT_CYC = 10_000_000,
    parameter logic [7:0]  HEADER      = 8'hA5
) (
    input logic               clk,
    input logic               rst,
    uart_boot_loader_if.slave bus
);
    localparam int unsigned       TMR_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR
    } state_t;

    state_t            state_reg;
    logic              rx_ready_q;
    logic [15:0]       len_reg;
    logic [15:0]       word_idx_reg;
    logic [1:0]        byte_idx_reg;
    logic [7:0]        xor_reg;
    logic [23:0]       word_reg;
    logic [TMR_W-1:0]  tmr_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [31:0]       mem_wdata_reg;
    logic              cpu_hold_reg;
    logic              load_done_reg;
    logic              load_err_reg;

    logic byte_stb;
    logic timed_out;

    assign byte_stb  = bus.rx_ready & ~rx_ready_q;
    // The timer only runs in the frame-parsing states, so this is harmless elsewhere.
    assign timed_out = ~byte_stb && (tmr_reg == TMR_LAST);

    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.cpu_hold  = cpu_hold_reg;
    assign bus.load_done = load_done_reg;
    assign bus.load_err  = load_err_reg;
    assign bus.busy      = (state_reg != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            rx_ready_q    <= 1'b0;
            len_reg       <= '0;
            word_idx_reg  <= '0;
            byte_idx_reg  <= '0;
            xor_reg       <= '0;
            word_reg      <= '0;
            tmr_reg       <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= BASE;
            mem_wdata_reg <= '0;
            cpu_hold_reg  <= 1'b0;
            load_done_reg <= 1'b0;
            load_err_reg  <= 1'b0;
        end else begin
            rx_ready_q    <= bus.rx_ready;
            mem_we_reg    <= 1'b0;
            load_done_reg <= 1'b0;

            if (byte_stb || state_reg == IDLE || state_reg == DONE || state_reg == ERR)
                tmr_reg <= '0;
            else
                tmr_reg <= tmr_reg + 1'b1;

            case (state_reg)
                IDLE: begin
                    if (byte_stb && bus.rx_data == HEADER) begin
                        state_reg    <= LEN_LO;
                        cpu_hold_reg <= 1'b1;
                        load_err_reg <= 1'b0;
                        xor_reg      <= '0;
                        word_idx_reg <= '0;
                        byte_idx_reg <= '0;
                    end
                end
                LEN_LO: begin
                    if (timed_out) begin
                        state_reg <= ERR;
                    end else if (byte_stb) begin
                        len_reg[7:0] <= bus.rx_data;
                        xor_reg      <= xor_reg ^ bus.rx_data;
                        state_reg    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (timed_out) begin
                        state_reg <= ERR;
                    end else if (byte_stb) begin
                        len_reg[15:8] <= bus.rx_data;
                        xor_reg       <= xor_reg ^ bus.rx_data;
                        state_reg     <= ({bus.rx_data, len_reg[7:0]} != 16'd0) ? DATA : CSUM;
                    end
                end
                DATA: begin
                    if (timed_out) begin
                        state_reg <= ERR;
                    end else if (byte_stb) begin
                        word_reg     <= {word_reg[15:0], bus.rx_data};
                        xor_reg      <= xor_reg ^ bus.rx_data;
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                        // Fourth byte completes a big-endian word; address wraps with ADDR_W.
                        if (byte_idx_reg == 2'd3) begin
                            mem_we_reg    <= 1'b1;
                            mem_addr_reg  <= BASE + ADDR_W'(word_idx_reg);
                            mem_wdata_reg <= {word_reg, bus.rx_data};
                            word_idx_reg  <= word_idx_reg + 16'd1;
                            if (word_idx_reg + 16'd1 == len_reg)
                                state_reg <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (timed_out) begin
                        state_reg <= ERR;
                    end else if (byte_stb) begin
                        state_reg <= (bus.rx_data == xor_reg) ? DONE : ERR;
                    end
                end
                DONE: begin
                    load_done_reg <= 1'b1;
                    cpu_hold_reg  <= 1'b0;
                    state_reg     <= IDLE;
                end
                ERR: begin
                    // cpu_hold deliberately stays high: a failed load must not release the core.
                    load_err_reg <= 1'b1;
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: randomized frames against a frame-level
// model of expected writes, checksum outcome and status timing.
module tb_uart_boot_loader;
    localparam int          AW1 = 10;
    localparam int          AW2 = 2;
    localparam int          TO  = 1000;
    localparam logic [7:0]  HDR = 8'hA5;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_ready;
    logic [7:0] rx_data;

    uart_boot_loader_if #(.ADDR_W(AW1)) bus1();
    uart_boot_loader_if #(.ADDR_W(AW2)) bus2();

    assign bus1.rx_ready = rx_ready;
    assign bus1.rx_data  = rx_data;
    assign bus2.rx_ready = rx_ready;
    assign bus2.rx_data  = rx_data;

    uart_boot_loader #(.ADDR_W(AW1), .BASE_ADDR(0), .TIMEOUT_CYC(TO), .HEADER(HDR)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );
    uart_boot_loader #(.ADDR_W(AW2), .BASE_ADDR(0), .TIMEOUT_CYC(TO), .HEADER(HDR)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    always #5 clk = ~clk;

    wr_t        wq1[$];
    wr_t        wq2[$];
    wr_t        exp1[$];
    wr_t        exp2[$];
    logic [7:0] frm[$];
    int         stbq[$];
    int         cyc      = 0;
    int         done_cnt = 0;
    int         hold_cnt = 0;
    int         checks   = 0;
    int         errors   = 0;
    logic       exp_ok;
    logic       last_hold, last_busy;
    logic       s_hdr_hold, s_hdr_busy;
    logic [7:0] s_end;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus1.mem_we) wq1.push_back(wr_t'({32'(cyc), 32'(bus1.mem_addr), bus1.mem_wdata}));
        if (bus2.mem_we) wq2.push_back(wr_t'({32'(cyc), 32'(bus2.mem_addr), bus2.mem_wdata}));
        if (bus1.load_done) done_cnt++;
        if (bus1.cpu_hold) hold_cnt++;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        stbq.push_back(cyc);
        @(negedge clk);
        last_hold = bus1.cpu_hold;
        last_busy = bus1.busy;
        repeat (hold - 1) @(negedge clk);
        rx_ready = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    // Sends frm; the checksum byte is followed cycle by cycle to capture end-of-frame status.
    task automatic send_frame(input int hold);
        stbq.delete();
        wq1.delete();
        wq2.delete();
        for (int k = 0; k < frm.size() - 1; k++) begin
            send_byte(frm[k], hold);
            if (k == 0) begin
                s_hdr_hold = last_hold;
                s_hdr_busy = last_busy;
            end
        end
        @(negedge clk);
        rx_data  = frm[frm.size() - 1];
        rx_ready = 1'b1;
        stbq.push_back(cyc);
        @(negedge clk);
        s_end[7:5] = {bus1.busy, bus1.load_done, bus1.load_err};
        @(negedge clk);
        rx_ready = 1'b0;
        s_end[4:1] = {bus1.load_done, bus1.cpu_hold, bus1.load_err, bus1.busy};
        @(negedge clk);
        s_end[0] = bus1.load_done;
    endtask

    task automatic build_frame(input int len, input bit corrupt);
        logic [7:0] x;
        logic [7:0] b;
        frm.delete();
        frm.push_back(HDR);
        frm.push_back(len[7:0]);
        frm.push_back(len[15:8]);
        for (int i = 0; i < 4 * len; i++) begin
            b = 8'($urandom_range(0, 255));
            frm.push_back(b);
        end
        x = 8'h00;
        for (int i = 1; i < frm.size(); i++) x = x ^ frm[i];
        if (corrupt) x = x ^ 8'($urandom_range(1, 255));
        frm.push_back(x);
    endtask

    // Frame-level reference: one write per 4 payload bytes, visible the cycle after the
    // 4th byte's strobe, at word index modulo memory depth; checksum is XOR after header.
    task automatic model_frame();
        int         n;
        logic [7:0] x;
        logic [31:0] w;
        exp1.delete();
        exp2.delete();
        n = int'(frm[1]) + 256 * int'(frm[2]);
        for (int i = 0; i < n; i++) begin
            w = {frm[3 + 4*i], frm[4 + 4*i], frm[5 + 4*i], frm[6 + 4*i]};
            exp1.push_back(wr_t'({32'(stbq[6 + 4*i] + 1), 32'(i % (1 << AW1)), w}));
            exp2.push_back(wr_t'({32'(stbq[6 + 4*i] + 1), 32'(i % (1 << AW2)), w}));
        end
        x = 8'h00;
        for (int i = 1; i < frm.size() - 1; i++) x = x ^ frm[i];
        exp_ok = (frm[frm.size() - 1] == x);
    endtask

    task automatic test_reset();
        logic [45:0] got1, got2;
        rst = 1'b1;
        rx_ready = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(negedge clk);
        got1 = {bus1.mem_we, bus1.mem_addr, bus1.mem_wdata, bus1.cpu_hold, bus1.load_done, bus1.load_err, bus1.busy};
        checks++;
        if (got1 !== 46'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", got1);
        end
        got2 = 46'({bus2.mem_we, bus2.mem_addr, bus2.mem_wdata, bus2.cpu_hold, bus2.load_done, bus2.load_err, bus2.busy});
        checks++;
        if (got2 !== 46'd0) begin
            errors++;
            $display("FAIL reset_outputs_aw2 got %h exp 0", got2);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_spec_frame();
        int d0;
        frm = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
        for (int i = 1; i < 11; i++) frm[11] = frm[11] ^ frm[i];
        d0 = done_cnt;
        send_frame(1);
        model_frame();
        checks++;
        if ({s_hdr_hold, s_hdr_busy} !== 2'b11) begin
            errors++;
            $display("FAIL spec_hdr hold/busy got %b exp 11", {s_hdr_hold, s_hdr_busy});
        end
        checks++;
        if (s_end !== {3'b100, exp_ok, ~exp_ok, ~exp_ok, 2'b00}) begin
            errors++;
            $display("FAIL spec_end got %b exp %b", s_end, {3'b100, exp_ok, ~exp_ok, ~exp_ok, 2'b00});
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL spec_done_count got %0d exp 1", done_cnt - d0);
        end
        checks++;
        if (wq1.size() != 2) begin
            errors++;
            $display("FAIL spec_write_count got %0d exp 2", wq1.size());
        end else begin
            foreach (exp1[i]) begin
                checks++;
                if (wq1[i] !== exp1[i]) begin
                    errors++;
                    $display("FAIL spec_write[%0d] got %h exp %h (cyc,addr,data)", i, wq1[i], exp1[i]);
                end
            end
            checks++;
            if (wq1[1].data !== 32'hDEADBEEF || wq1[0].data !== 32'h11223344) begin
                errors++;
                $display("FAIL spec_write_data got %h %h exp 11223344 deadbeef", wq1[0].data, wq1[1].data);
            end
        end
    endtask

    task automatic test_bad_csum();
        int d0;
        frm = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h47};
        d0 = done_cnt;
        send_frame(1);
        model_frame();
        checks++;
        if (s_end !== {3'b100, exp_ok, ~exp_ok, ~exp_ok, 2'b00} || exp_ok !== 1'b0) begin
            errors++;
            $display("FAIL bad_end got %b exp %b", s_end, {3'b100, exp_ok, ~exp_ok, ~exp_ok, 2'b00});
        end
        checks++;
        if (done_cnt != d0 || wq1.size() != 2) begin
            errors++;
            $display("FAIL bad_done_writes got done %0d writes %0d exp 0 2", done_cnt - d0, wq1.size());
        end
        build_frame($urandom_range(1, 3), 1'b0);
        send_frame(1);
        model_frame();
        checks++;
        if (s_end !== 8'b10010000) begin
            errors++;
            $display("FAIL bad_recover_end got %b exp 10010000", s_end);
        end
    endtask

    task automatic test_zero_len();
        int d0;
        frm = '{8'hA5, 8'h00, 8'h00, 8'h00};
        d0 = done_cnt;
        hold_cnt = 0;
        send_frame(1);
        model_frame();
        checks++;
        if (s_end !== 8'b10010000 || done_cnt - d0 != 1 || wq1.size() != 0) begin
            errors++;
            $display("FAIL zero_len got end %b done %0d writes %0d exp 10010000 1 0", s_end, done_cnt - d0, wq1.size());
        end
        checks++;
        if (hold_cnt != stbq[3] - stbq[0] + 1) begin
            errors++;
            $display("FAIL zero_len_hold_cycles got %0d exp %0d", hold_cnt, stbq[3] - stbq[0] + 1);
        end
    endtask

    task automatic test_preamble_long_hold();
        send_byte(8'h55, 5);
        checks++;
        if ({last_busy, last_hold} !== 2'b00) begin
            errors++;
            $display("FAIL preamble_55 busy/hold got %b exp 00", {last_busy, last_hold});
        end
        send_byte(8'h13, 5);
        checks++;
        if ({last_busy, last_hold} !== 2'b00) begin
            errors++;
            $display("FAIL preamble_13 busy/hold got %b exp 00", {last_busy, last_hold});
        end
        build_frame(1, 1'b0);
        send_frame(5);
        model_frame();
        checks++;
        if (s_end !== 8'b10010000 || {s_hdr_busy, s_hdr_hold} !== 2'b11) begin
            errors++;
            $display("FAIL preamble_end got %b hdr %b exp 10010000 11", s_end, {s_hdr_busy, s_hdr_hold});
        end
        checks++;
        if (wq1.size() != 1 || wq1[0] !== exp1[0]) begin
            errors++;
            $display("FAIL preamble_write got n=%0d exp %h", wq1.size(), exp1[0]);
        end
    endtask

    task automatic test_timeout();
        int t0;
        int seen;
        stbq.delete();
        send_byte(HDR, 1);
        send_byte(8'($urandom_range(0, 255)), 1);
        t0 = stbq[1];
        seen = -1;
        for (int n = 0; n < 3 * TO; n++) begin
            @(negedge clk);
            if (bus1.load_err) begin
                seen = cyc;
                break;
            end
        end
        checks++;
        if (seen != t0 + 2 + TO) begin
            errors++;
            $display("FAIL timeout_err_cycle got %0d exp %0d", seen, t0 + 2 + TO);
        end
        checks++;
        if ({bus1.busy, bus1.cpu_hold, bus1.load_done} !== 3'b010) begin
            errors++;
            $display("FAIL timeout_state busy/hold/done got %b exp 010", {bus1.busy, bus1.cpu_hold, bus1.load_done});
        end
    endtask

    task automatic test_rst_midframe();
        logic [45:0] got;
        build_frame(2, 1'b0);
        stbq.delete();
        wq1.delete();
        for (int k = 0; k < 9; k++) send_byte(frm[k], 1);
        checks++;
        if (wq1.size() != 1) begin
            errors++;
            $display("FAIL rst_pre_write_count got %0d exp 1", wq1.size());
        end
        #2 rst = 1'b1;
        #1 got = {bus1.mem_we, bus1.mem_addr, bus1.mem_wdata, bus1.cpu_hold, bus1.load_done, bus1.load_err, bus1.busy};
        checks++;
        if (got !== 46'd0) begin
            errors++;
            $display("FAIL rst_midframe_outputs got %h exp 0", got);
        end
        @(negedge clk);
        rst = 1'b0;
        build_frame(2, 1'b0);
        send_frame(1);
        model_frame();
        checks++;
        if (s_end !== 8'b10010000 || wq1.size() != 2) begin
            errors++;
            $display("FAIL rst_reload got end %b writes %0d exp 10010000 2", s_end, wq1.size());
        end else begin
            foreach (exp1[i]) begin
                checks++;
                if (wq1[i] !== exp1[i]) begin
                    errors++;
                    $display("FAIL rst_reload_write[%0d] got %h exp %h", i, wq1[i], exp1[i]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        build_frame(5, 1'b0);
        send_frame(2);
        model_frame();
        checks++;
        if (wq2.size() != 5 || wq1.size() != 5) begin
            errors++;
            $display("FAIL wrap_write_count got %0d/%0d exp 5/5", wq1.size(), wq2.size());
        end else begin
            foreach (exp2[i]) begin
                checks++;
                if (wq2[i] !== exp2[i] || wq1[i] !== exp1[i]) begin
                    errors++;
                    $display("FAIL wrap_write[%0d] got %h / %h exp %h / %h", i, wq2[i], wq1[i], exp2[i], exp1[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        for (int it = 0; it < 5; it++) begin
            build_frame($urandom_range(0, 6), $urandom_range(0, 2) == 0);
            d0 = done_cnt;
            send_frame($urandom_range(1, 3));
            model_frame();
            checks++;
            if (s_end !== {3'b100, exp_ok, ~exp_ok, ~exp_ok, 2'b00} || done_cnt - d0 != int'(exp_ok)) begin
                errors++;
                $display("FAIL b2b[%0d]_end got %b done %0d exp %b %0d", it, s_end, done_cnt - d0,
                         {3'b100, exp_ok, ~exp_ok, ~exp_ok, 2'b00}, exp_ok);
            end
            checks++;
            if (wq1.size() != exp1.size()) begin
                errors++;
                $display("FAIL b2b[%0d]_write_count got %0d exp %0d", it, wq1.size(), exp1.size());
            end else begin
                foreach (exp1[i]) begin
                    checks++;
                    if (wq1[i] !== exp1[i]) begin
                        errors++;
                        $display("FAIL b2b[%0d]_write[%0d] got %h exp %h", it, i, wq1[i], exp1[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_spec_frame();
        test_bad_csum();
        test_zero_len();
        test_preamble_long_hold();
        test_timeout();
        test_rst_midframe();
        test_wrap();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
